// File: rtl/ddr_rd_engine.sv
// ddr_rd_engine: DDR read engine for one ddr2pe read port.
// Issues a strided sequence of read bursts with a cap on bursts in flight,
// and routes the returned beat stream to one of CONS_NUM buffer writers.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, busy, done        transfer control / status
//   conf_st_addr, conf_burst, conf_step, conf_burst_num, conf_dest
//                            transfer config, sampled on an accepted start
//   ddr_addr, ddr_size, ddr_addr_valid, ddr_addr_ready
//                            burst request channel (registered)
//   ddr_valid, ddr_ready     return-data handshake
//   cons_valid, cons_ready, cons_last
//                            per-consumer beat steering (combinational)
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | issuing requests and routing returned beats
// S_DONE | one-cycle completion pulse
module ddr_rd_engine #(
  parameter int DDR_ADDR_W      = 32,
  parameter int BURST_W         = 8,
  parameter int CONS_NUM        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic [DDR_ADDR_W-1:0]       conf_st_addr,
  input  logic [BURST_W-1:0]          conf_burst,
  input  logic [DDR_ADDR_W-1:0]       conf_step,
  input  logic [BURST_W-1:0]          conf_burst_num,
  input  logic [$clog2(CONS_NUM)-1:0] conf_dest,
  output logic [DDR_ADDR_W-1:0]       ddr_addr,
  output logic [BURST_W-1:0]          ddr_size,
  output logic                        ddr_addr_valid,
  input  logic                        ddr_addr_ready,
  input  logic                        ddr_valid,
  output logic                        ddr_ready,
  output logic [CONS_NUM-1:0]         cons_valid,
  input  logic [CONS_NUM-1:0]         cons_ready,
  output logic                        cons_last
);

  localparam int DEST_W = $clog2(CONS_NUM);
  localparam logic [BURST_W-1:0] ONE_B   = BURST_W'(1);
  localparam logic [3:0]         MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [BURST_W-1:0]    burst;
  logic [BURST_W-1:0]    burst_num;
  logic [DDR_ADDR_W-1:0] step;
  logic [DEST_W-1:0]     dest;
  logic [DDR_ADDR_W-1:0] next_addr;
  logic [BURST_W-1:0]    req_cnt;
  logic [BURST_W-1:0]    beat_cnt;
  logic [BURST_W-1:0]    bst_cnt;
  logic [3:0]            out_cnt;
  logic [3:0]            acc_cnt;

  logic       data_en;
  logic       sel_ready;
  logic       beat_hs;
  logic       burst_done;
  logic       addr_hs;
  logic       raise;
  logic [3:0] out_eff;

  assign data_en    = (state == S_RUN) && (acc_cnt != 4'd0);
  assign ddr_ready  = data_en && sel_ready;
  assign beat_hs    = ddr_valid && ddr_ready;
  assign cons_last  = data_en && ddr_valid && (beat_cnt == burst - ONE_B);
  assign burst_done = beat_hs && (beat_cnt == burst - ONE_B);
  assign addr_hs    = ddr_addr_valid && ddr_addr_ready;
  // A credit freed this cycle may be reused immediately, so a stalled
  // request shows up the cycle after the completing beat.
  assign out_eff    = out_cnt - 4'(burst_done);
  assign raise      = (state == S_RUN) && (!ddr_addr_valid || ddr_addr_ready) &&
                      (req_cnt < burst_num) && (out_eff < MAX_OUT);

  always_comb begin
    sel_ready  = 1'b0;
    cons_valid = '0;
    for (int i = 0; i < CONS_NUM; i++) begin
      if (dest == DEST_W'(i)) begin
        sel_ready     = cons_ready[i];
        cons_valid[i] = data_en && ddr_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      ddr_addr_valid <= 1'b0;
      ddr_addr       <= '0;
      ddr_size       <= '0;
      burst          <= '0;
      burst_num      <= '0;
      step           <= '0;
      dest           <= '0;
      next_addr      <= '0;
      req_cnt        <= '0;
      beat_cnt       <= '0;
      bst_cnt        <= '0;
      out_cnt        <= '0;
      acc_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            burst     <= conf_burst;
            burst_num <= conf_burst_num;
            step      <= conf_step;
            dest      <= conf_dest;
            ddr_size  <= conf_burst;
            beat_cnt  <= '0;
            bst_cnt   <= '0;
            acc_cnt   <= '0;
            if (conf_burst == '0 || conf_burst_num == '0) begin
              state   <= S_DONE;
              done    <= 1'b1;
              req_cnt <= '0;
              out_cnt <= '0;
            end else begin
              // First request is presented straight from the config.
              state          <= S_RUN;
              busy           <= 1'b1;
              ddr_addr_valid <= 1'b1;
              ddr_addr       <= conf_st_addr;
              next_addr      <= conf_st_addr + conf_step;
              req_cnt        <= ONE_B;
              out_cnt        <= 4'd1;
            end
          end
        end
        S_RUN: begin
          if (raise) begin
            ddr_addr_valid <= 1'b1;
            ddr_addr       <= next_addr;
            next_addr      <= next_addr + step;
            req_cnt        <= req_cnt + ONE_B;
          end else if (addr_hs) begin
            ddr_addr_valid <= 1'b0;
          end
          out_cnt <= out_cnt + 4'(raise) - 4'(burst_done);
          acc_cnt <= acc_cnt + 4'(addr_hs) - 4'(burst_done);
          if (beat_hs)
            beat_cnt <= burst_done ? '0 : beat_cnt + ONE_B;
          if (burst_done) begin
            bst_cnt <= bst_cnt + ONE_B;
            if (bst_cnt == burst_num - ONE_B) begin
              state          <= S_DONE;
              busy           <= 1'b0;
              done           <= 1'b1;
              ddr_addr_valid <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          req_cnt  <= '0;
          beat_cnt <= '0;
          bst_cnt  <= '0;
          out_cnt  <= '0;
          acc_cnt  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
